fetch_unit: RTL and testbench

//  Instruction fetch stage. Sits directly upstream of decode and consumes the

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one outstanding imem word request and queues {pc, word} for decode.
// Latency: one cycle minimum from imem_ack to inst_valid; a redirect takes effect on the next cycle.
// Backpressure: a full queue or halt stops new requests; the queue head is held while decode is not ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_fetch,
  input  logic [31:0] new_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  // WAIT_DROP means the outstanding response belongs to a path abandoned by a redirect.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t         r_state;
  logic [31:0]    r_pc;
  logic [31:0]    r_req_addr;
  logic [31:0]    r_q_pc   [FIFO_DEPTH];
  logic [31:0]    r_q_inst [FIFO_DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic           w_outstanding;
  logic           w_full;
  logic           w_empty;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;
  logic [31:0]    w_redirect_pc;

  assign w_outstanding = (r_state != IDLE);
  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  // A request is only started when its response is guaranteed a queue slot.
  assign w_issue       = !reset && !halt && !ctrl_fetch && !w_outstanding && !w_full;
  // Responses are kept only when the request is still on the current path.
  assign w_push        = imem_ack && (r_state == WAIT) && !ctrl_fetch;
  assign w_pop         = inst_valid && inst_ready;
  assign w_redirect_pc = new_pc & 32'hFFFF_FFFC;

  // Once raised, the request holds its address until the memory acknowledges it.
  assign imem_req   = !reset && (w_outstanding || w_issue);
  assign imem_addr  = w_outstanding ? r_req_addr : r_pc;

  assign inst_valid = !reset && !w_empty && !halt && !ctrl_fetch;
  assign inst       = inst_valid ? r_q_inst[r_rd_ptr] : NOP_INST;
  assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : 32'h0000_0000;

  // Request tracking: issue, completion, and marking a wrong-path response for discard.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req_addr <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state    <= WAIT;
            r_req_addr <= r_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            r_state <= IDLE;
          end else if (ctrl_fetch) begin
            r_state <= WAIT_DROP;
          end
        end
        WAIT_DROP: begin
          if (imem_ack) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Program counter: a redirect wins, otherwise advance past each accepted word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (ctrl_fetch) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Queue bookkeeping: a redirect flushes everything, including this cycle's push and pop.
  always_ff @(posedge clock) begin
    if (reset || ctrl_fetch) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: each entry pairs the fetched word with the address it came from.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_req_addr;
      r_q_inst[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_fetch;
  logic [31:0] new_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH),
    .NOP_INST   (NOP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_fetch (ctrl_fetch),
    .new_pc     (new_pc),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the delivered stream is sequential from the last redirect target.
  logic [31:0] m_fetch_pc;
  logic [31:0] m_deliv_pc;
  logic [31:0] m_req_addr;
  int          m_cnt;
  bit          m_out;
  bit          m_drop;
  int          m_age;
  int          m_delay;
  int          n_issue = 0;
  logic [31:0] dlog[$];

  // Memory responder configuration.
  int          mem_lo = 1;
  int          mem_hi = 1;
  bit          slow_en = 0;
  logic [31:0] slow_addr = 32'h0;
  int          slow_delay = 1;
  bit          force_ack = 0;
  logic [31:0] salt;

  // Sampled outputs of the most recent cycle.
  logic        s_req, s_valid, s_ack;
  logic [31:0] s_addr, s_inst, s_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic tick();
    logic exp_req, exp_valid, pop, good;
    logic [31:0] exp_addr;
    @(negedge clock);
    s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
    s_inst = inst; s_pc = inst_pc; s_ack = imem_ack;
    if (reset) begin
      n_cmp++;
      if (s_req !== 1'b0 || s_valid !== 1'b0 || s_inst !== NOP || s_pc !== 32'h0) begin
        n_err++;
        $display("FAIL reset_outputs: req=%b valid=%b inst=%h pc=%h, want 0 0 %h 0", s_req, s_valid, s_inst, s_pc, NOP);
      end
      m_cnt = 0; m_out = 0; m_drop = 0; m_age = 0;
      m_fetch_pc = RESET_PC; m_deliv_pc = RESET_PC;
    end else begin
      exp_valid = (m_cnt > 0) && !halt && !ctrl_fetch;
      exp_req   = m_out || (!halt && !ctrl_fetch && (m_cnt < DEPTH));
      n_cmp++;
      if (s_valid !== exp_valid) begin
        n_err++;
        $display("FAIL inst_valid @%0t: got %b want %b", $time, s_valid, exp_valid);
      end
      n_cmp++;
      if (exp_valid) begin
        if (s_pc !== m_deliv_pc || s_inst !== mdata(m_deliv_pc)) begin
          n_err++;
          $display("FAIL head @%0t: pc=%h inst=%h want pc=%h inst=%h", $time, s_pc, s_inst, m_deliv_pc, mdata(m_deliv_pc));
        end
      end else if (s_inst !== NOP) begin
        n_err++;
        $display("FAIL nop_when_idle @%0t: inst=%h want %h", $time, s_inst, NOP);
      end
      n_cmp++;
      if (s_req !== exp_req) begin
        n_err++;
        $display("FAIL imem_req @%0t: got %b want %b", $time, s_req, exp_req);
      end
      if (s_req === 1'b1) begin
        exp_addr = m_out ? m_req_addr : m_fetch_pc;
        n_cmp++;
        if (s_addr !== exp_addr) begin
          n_err++;
          $display("FAIL imem_addr @%0t: got %h want %h", $time, s_addr, exp_addr);
        end
      end
      pop  = exp_valid && inst_ready;
      good = s_ack && m_out && !m_drop && !ctrl_fetch;
      if (pop) dlog.push_back(m_deliv_pc);
      if (ctrl_fetch) begin
        m_cnt = 0;
        m_fetch_pc = {new_pc[31:2], 2'b00};
        m_deliv_pc = m_fetch_pc;
        if (m_out && !s_ack) m_drop = 1;
      end else begin
        if (pop) begin m_cnt--; m_deliv_pc = m_deliv_pc + 32'd4; end
        if (good) begin m_cnt++; m_fetch_pc = m_fetch_pc + 32'd4; end
      end
      if (m_out && s_ack) begin
        m_out = 0; m_drop = 0;
      end else if (!m_out && s_req === 1'b1) begin
        m_out = 1; m_req_addr = s_addr; m_age = 0; n_issue++;
        m_delay = (slow_en && s_addr == slow_addr) ? slow_delay : int'($urandom_range(mem_hi, mem_lo));
      end
      if (m_out) m_age++;
    end
    @(posedge clock);
    #1;
    if (force_ack) begin
      imem_ack = 1'b1; imem_rdata = $urandom; force_ack = 0;
    end else if (m_out && m_age >= m_delay) begin
      imem_ack = 1'b1; imem_rdata = mdata(m_req_addr);
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; ctrl_fetch = 1'b0; halt = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
    dlog.delete();
  endtask

  task automatic timeout_fail(input string what);
    n_cmp++; n_err++;
    $display("FAIL timeout_%s: event not seen within cycle budget", what);
  endtask

  task automatic test_reset();
    inst_ready = 1'b1; slow_en = 0; mem_lo = 1; mem_hi = 1;
    do_reset(3);
    tick();
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h", s_req, s_addr, RESET_PC);
    end
    n_cmp++;
    if (s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL first_valid: got %b want 0", s_valid);
    end
  endtask

  task automatic test_straight();
    inst_ready = 1'b1;
    do_reset(2);
    for (int i = 0; i < 40 && dlog.size() < 4; i++) tick();
    if (dlog.size() < 4) timeout_fail("straight");
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dlog[i] !== RESET_PC + 32'(4 * i)) begin
        n_err++;
        $display("FAIL straight_pc[%0d]: got %h want %h", i, dlog[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 3) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_pc !== RESET_PC || s_inst !== mdata(RESET_PC)) begin
          n_err++;
          $display("FAIL bp_hold[%0d]: valid=%b pc=%h inst=%h want 1 %h %h", i, s_valid, s_pc, s_inst, RESET_PC, mdata(RESET_PC));
        end
      end
    end
    n_cmp++;
    if (s_req !== 1'b0 || dlog.size() != 0) begin
      n_err++;
      $display("FAIL bp_full: req=%b popped=%0d want 0 0", s_req, dlog.size());
    end
    inst_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (s_valid !== 1'b1 || s_pc !== 32'h4 || s_req !== 1'b1 || s_addr !== 32'h8) begin
      n_err++;
      $display("FAIL bp_release: valid=%b pc=%h req=%b addr=%h want 1 4 1 8", s_valid, s_pc, s_req, s_addr);
    end
    for (int i = 0; i < 30 && dlog.size() < 3; i++) tick();
    if (dlog.size() < 3) timeout_fail("backpressure");
    else begin
      n_cmp++;
      if (dlog[0] !== 32'h0 || dlog[1] !== 32'h4 || dlog[2] !== 32'h8) begin
        n_err++;
        $display("FAIL bp_order: got %h %h %h want 0 4 8", dlog[0], dlog[1], dlog[2]);
      end
    end
  endtask

  task automatic test_redirect_drop();
    bit found = 0;
    inst_ready = 1'b1;
    do_reset(2);
    slow_en = 1; slow_addr = 32'h10; slow_delay = 4;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (s_req === 1'b1 && s_addr === 32'h10) found = 1;
    end
    if (!found) timeout_fail("drop_req");
    ctrl_fetch = 1'b1; new_pc = 32'h100;
    tick();
    ctrl_fetch = 1'b0;
    dlog.delete();
    tick();
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h10) begin
      n_err++;
      $display("FAIL drop_hold: req=%b addr=%h want 1 00000010", s_req, s_addr);
    end
    for (int i = 0; i < 40 && dlog.size() < 2; i++) tick();
    if (dlog.size() < 2) timeout_fail("drop_deliver");
    else begin
      n_cmp++;
      if (dlog[0] !== 32'h100 || dlog[1] !== 32'h104) begin
        n_err++;
        $display("FAIL drop_target: got %h %h want 00000100 00000104", dlog[0], dlog[1]);
      end
    end
    slow_en = 0;
  endtask

  task automatic test_redirect_same();
    bit found = 0;
    inst_ready = 1'b1;
    do_reset(2);
    slow_en = 1; slow_addr = 32'h8; slow_delay = 2;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (s_req === 1'b1 && s_addr === 32'h8) found = 1;
    end
    if (!found) timeout_fail("same_req");
    tick();
    ctrl_fetch = 1'b1; new_pc = 32'h200;
    tick();
    ctrl_fetch = 1'b0;
    tick();
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h200 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL same_cycle_ack: req=%b addr=%h valid=%b want 1 00000200 0", s_req, s_addr, s_valid);
    end
    slow_en = 0;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ctrl_fetch = 1'b1; new_pc = 32'h103;
    tick();
    ctrl_fetch = 1'b0; halt = 1'b0;
    tick();
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_redirect: req=%b addr=%h valid=%b want 1 00000100 0", s_req, s_addr, s_valid);
    end
  endtask

  task automatic test_halt();
    bit found = 0;
    int issues0;
    inst_ready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_valid === 1'b1) found = 1;
    end
    if (!found) timeout_fail("halt_fill");
    issues0 = n_issue;
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (s_valid !== 1'b0) begin
        n_err++;
        $display("FAIL halt_valid[%0d]: got %b want 0", i, s_valid);
      end
    end
    n_cmp++;
    if (n_issue != issues0) begin
      n_err++;
      $display("FAIL halt_issue: %0d new requests during halt, want 0", n_issue - issues0);
    end
    halt = 1'b0; inst_ready = 1'b1;
    tick();
    n_cmp++;
    if (s_valid !== 1'b1 || s_pc !== RESET_PC) begin
      n_err++;
      $display("FAIL halt_release: valid=%b pc=%h want 1 %h", s_valid, s_pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    bit seen_top = 0;
    bit found = 0;
    inst_ready = 1'b1;
    do_reset(2);
    tick();
    ctrl_fetch = 1'b1; new_pc = 32'hFFFF_FFFE;
    tick();
    ctrl_fetch = 1'b0;
    dlog.delete();
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (s_req === 1'b1 && s_addr === 32'hFFFF_FFFC) seen_top = 1;
      else if (seen_top && s_req === 1'b1 && s_addr === 32'h0) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL wrap_addr: no request at 00000000 after FFFFFFFC (seen_top=%b)", seen_top);
    end
    for (int i = 0; i < 30 && dlog.size() < 2; i++) tick();
    if (dlog.size() < 2) timeout_fail("wrap_deliver");
    else begin
      n_cmp++;
      if (dlog[0] !== 32'hFFFF_FFFC || dlog[1] !== 32'h0) begin
        n_err++;
        $display("FAIL wrap_stream: got %h %h want fffffffc 00000000", dlog[0], dlog[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    inst_ready = 1'b1;
    do_reset(2);
    slow_en = 1; slow_addr = 32'h4; slow_delay = 8;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (s_req === 1'b1 && s_addr === 32'h4) found = 1;
    end
    if (!found) timeout_fail("mid_req");
    reset = 1'b1; force_ack = 1;
    tick();
    reset = 1'b0;
    dlog.delete();
    slow_en = 0;
    tick();
    n_cmp++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ack: req=%b addr=%h valid=%b want 1 %h 0", s_req, s_addr, s_valid, RESET_PC);
    end
    for (int i = 0; i < 30 && dlog.size() < 2; i++) tick();
    if (dlog.size() < 2) timeout_fail("mid_deliver");
    else begin
      n_cmp++;
      if (dlog[0] !== RESET_PC || dlog[1] !== RESET_PC + 32'd4) begin
        n_err++;
        $display("FAIL mid_stream: got %h %h want %h %h", dlog[0], dlog[1], RESET_PC, RESET_PC + 32'd4);
      end
    end
  endtask

  task automatic test_random();
    inst_ready = 1'b1;
    do_reset(2);
    slow_en = 0; mem_lo = 1; mem_hi = 3;
    for (int i = 0; i < 800; i++) begin
      inst_ready = ($urandom_range(3, 0) != 0);
      halt       = ($urandom_range(9, 0) == 0);
      ctrl_fetch = ($urandom_range(24, 0) == 0);
      new_pc     = ($urandom_range(1, 0) == 0) ? $urandom : 32'($urandom_range(255, 0));
      tick();
    end
    ctrl_fetch = 1'b0; halt = 1'b0;
    mem_lo = 1; mem_hi = 1;
    n_cmp++;
    if (dlog.size() < 40) begin
      n_err++;
      $display("FAIL random_progress: %0d words delivered, want at least 40", dlog.size());
    end
  endtask

  initial begin
    salt = $urandom;
    reset = 1'b1; ctrl_fetch = 1'b0; new_pc = 32'h0; halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b1;
    m_cnt = 0; m_out = 0; m_drop = 0; m_age = 0; m_delay = 1;
    m_fetch_pc = RESET_PC; m_deliv_pc = RESET_PC; m_req_addr = RESET_PC;
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_drop();
    test_redirect_same();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
